fetch_line: RTL and testbench
=============================

Name: fetch_line

Overview:
- Cache-line read engine: fills a 512-bit line from main memory over the system bus.
- Sequence: wins the bus arbiter, issues one aligned address beat with a memory-read tag, then collects 8 response beats of 64 bits each. Presents the assembled line with a ready flag.
- Sits between the cache miss logic and the arbiter / system bus, as the read-side counterpart of the line write-back engine.

Parameters:
- BUS_DATA_WIDTH, 64, width of one bus beat.
- BUS_TAG_WIDTH, 13, width of request/response tags.
- LINE_BEATS, 8, beats per line; the line is BUS_DATA_WIDTH*LINE_BEATS bits.
- TIMEOUT_CYCLES, 1024, idle-cycle limit used only by the optional feature.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- enable  in  1  level request to fetch the line at addr; sampled in IDLE and DONE.
- addr  in  BUS_DATA_WIDTH  byte address of the line; low 6 bits ignored.
- abtr_grant  in  1  arbiter grant.
- abtr_reqcyc  out  1  arbiter request.
- bus_busy  out  1  this engine owns the bus.
- main_bus_reqcyc  out  1  request beat valid.
- main_bus_reqack  in  1  bus accepted the request beat.
- main_bus_req  out  BUS_DATA_WIDTH  request payload (address).
- main_bus_reqtag  out  BUS_TAG_WIDTH  request tag.
- main_bus_respcyc  in  1  response beat valid.
- main_bus_resp  in  BUS_DATA_WIDTH  response payload.
- main_bus_resptag  in  BUS_TAG_WIDTH  response tag.
- main_bus_respack  out  1  response beat consumed.
- data  out  BUS_DATA_WIDTH*LINE_BEATS  assembled line, beat 0 in bits [63:0].
- ready  out  1  data valid.
- error  out  1  fetch aborted (timeout); see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; beat counter 0; data cleared to 0.
  - All outputs 0: abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_req, main_bus_reqtag, main_bus_respack, ready, error.
  - Reset mid-fetch abandons the transfer at once and releases the bus.
- States and transitions:
  - IDLE: enable=1 -> ARB.
  - ARB: abtr_reqcyc=1; abtr_grant=1 -> ADDR.
  - ADDR: bus_busy=1, main_bus_reqcyc=1, main_bus_req={addr[63:6],6'b0}, main_bus_reqtag=`SYSBUS_READ<<12|`SYSBUS_MEMORY<<8. These hold until main_bus_reqack=1, then -> RECV with counter=0. addr is captured in ADDR, so later changes to addr do not affect the transfer.
  - RECV: bus_busy=1, main_bus_reqcyc=0, main_bus_req=0, main_bus_reqtag=0.
    - A beat is accepted when main_bus_respcyc=1 and main_bus_resptag[12:8] equals the request tag bits [12:8].
    - On an accepted beat: main_bus_respack=1 combinationally in the same cycle; data[counter*64 +: 64] <= main_bus_resp; counter increments.
    - Non-matching or absent beats: respack=0, no capture, no counter change.
    - The accepted beat with counter=LINE_BEATS-1 -> DONE.
  - DONE: bus_busy=0, ready=1, data stable. enable=1 -> ARB, and ready drops on the next edge. Otherwise stay in DONE.
- Latency: with immediate grant and reqack and back-to-back beats, ready rises 11 cycles after enable is sampled (ARB 1 + ADDR 1 + RECV 8 + 1).
- Gaps between beats are legal and unbounded unless the optional feature is enabled.
- Counter is 4 bits and never wraps; it is cleared on entry to ADDR.
- No bus output is driven outside ADDR/RECV except abtr_reqcyc in ARB.
- Simultaneous events:
  - abtr_grant in the same cycle as the arc into ARB is not seen until the next cycle.
  - A response beat arriving in ADDR, before reqack, is ignored.

Optional Feature:
- Macro: FETCH_LINE_TIMEOUT_EN.
- Defined:
  - An idle counter runs in RECV; it clears on each accepted beat and increments otherwise.
  - When it reaches TIMEOUT_CYCLES, state -> DONE with error=1, ready=0 and bus_busy=0. Data content is undefined.
  - error clears when enable next moves the FSM to ARB.
- Not defined: no idle counter, error is tied to 0, and RECV waits indefinitely.

Test Plan:
- Basic fill: reset, enable=1 with addr=0x1234_5678_9ABC_DEF7, grant and reqack immediate, beats 0x11..0x88 back-to-back -> main_bus_req=0x1234_5678_9ABC_DEC0, tag=0x1100 with memory=1 and read=1. Expect 8 respack pulses, data[63:0]=0x11, data[511:448]=0x88, ready high at cycle 11.
- Stalls: grant delayed 5 cycles, reqack delayed 3 cycles, 2-cycle gaps between beats -> abtr_reqcyc held 5 cycles, reqcyc/address held 3 cycles, respack only on beat cycles, data correct.
- Foreign tag: inject a beat with resptag=0x1000 mid-transfer -> no respack, no capture, counter unchanged, final line correct.
- Reset mid-RECV after 4 beats: reset=0 -> all outputs 0 immediately, without waiting for a clock edge. A new enable performs a full 8-beat fill.
- Back-to-back: enable held high in DONE -> ready falls the next cycle, ARB re-entered, and a second line with a new addr completes.
- FETCH_LINE_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, stop after 3 beats -> error=1 and bus_busy=0 after 16 idle cycles. Without the macro, the FSM stays in RECV.

Source files
------------

// File: rtl/fetch_line_if.sv
// fetch_line_if: arbiter and system-bus signals of the line fetch engine.
// master = fetch engine side, slave = arbiter / bus side.
interface fetch_line_if #(
  parameter int DW = 64,
  parameter int TW = 13
);
  logic          abtr_grant;
  logic          abtr_reqcyc;
  logic          bus_busy;
  logic          main_bus_reqcyc;
  logic          main_bus_reqack;
  logic [DW-1:0] main_bus_req;
  logic [TW-1:0] main_bus_reqtag;
  logic          main_bus_respcyc;
  logic [DW-1:0] main_bus_resp;
  logic [TW-1:0] main_bus_resptag;
  logic          main_bus_respack;

  modport master (
    input  abtr_grant,
    output abtr_reqcyc,
    output bus_busy,
    output main_bus_reqcyc,
    input  main_bus_reqack,
    output main_bus_req,
    output main_bus_reqtag,
    input  main_bus_respcyc,
    input  main_bus_resp,
    input  main_bus_resptag,
    output main_bus_respack
  );

  modport slave (
    output abtr_grant,
    input  abtr_reqcyc,
    input  bus_busy,
    input  main_bus_reqcyc,
    output main_bus_reqack,
    input  main_bus_req,
    input  main_bus_reqtag,
    output main_bus_respcyc,
    output main_bus_resp,
    output main_bus_resptag,
    input  main_bus_respack
  );
endinterface

// File: rtl/fetch_line.sv
// fetch_line: cache-line read engine, one address beat then LINE_BEATS data beats.
// Optional RECV idle timeout is enabled by defining FETCH_LINE_TIMEOUT_EN.
module fetch_line #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [BUS_DATA_WIDTH-1:0]          addr,
  fetch_line_if.master                       bus,
  output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] data,
  output logic                               ready,
  output logic                               error
);

  localparam int DW = BUS_DATA_WIDTH;
  localparam int TW = BUS_TAG_WIDTH;
  localparam int LW = DW * LINE_BEATS;
  localparam int SYSBUS_READ   = 1;
  localparam int SYSBUS_MEMORY = 1;
  localparam logic [TW-1:0] RD_TAG =
    TW'((SYSBUS_READ << 12) | (SYSBUS_MEMORY << 8));

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_RECV,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-7:0] addr_q, addr_d;
  logic [LW-1:0] data_q, data_d;
  logic          err_q, err_d;
  logic          hit;

`ifdef FETCH_LINE_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_q, idle_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  logic unused_bits;
  assign unused_bits = ^{addr[5:0], bus.main_bus_resptag[TW-6:0]};

  // Only the space/command tag field identifies our responses
  assign hit = bus.main_bus_respcyc &&
    (bus.main_bus_resptag[TW-1:TW-5] == RD_TAG[TW-1:TW-5]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef FETCH_LINE_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef FETCH_LINE_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef FETCH_LINE_TIMEOUT_EN
    idle_d  = idle_q;
`endif
    bus.abtr_reqcyc      = 1'b0;
    bus.bus_busy         = 1'b0;
    bus.main_bus_reqcyc  = 1'b0;
    bus.main_bus_req     = '0;
    bus.main_bus_reqtag  = '0;
    bus.main_bus_respack = 1'b0;
    ready                = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_ARB;
      end
      S_ARB: begin
        bus.abtr_reqcyc = 1'b1;
        if (bus.abtr_grant) begin
          state_d = S_ADDR;
          addr_d  = addr[DW-1:6];
          cnt_d   = '0;
        end
      end
      S_ADDR: begin
        bus.bus_busy        = 1'b1;
        bus.main_bus_reqcyc = 1'b1;
        bus.main_bus_req    = {addr_q, 6'b0};
        bus.main_bus_reqtag = RD_TAG;
        if (bus.main_bus_reqack) begin
          state_d = S_RECV;
          cnt_d   = '0;
`ifdef FETCH_LINE_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
      end
      S_RECV: begin
        bus.bus_busy = 1'b1;
        if (hit) begin
          bus.main_bus_respack = 1'b1;
          for (int i = 0; i < LINE_BEATS; i++) begin
            if (cnt_q == 4'(i)) data_d[i*DW +: DW] = bus.main_bus_resp;
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(LINE_BEATS - 1)) state_d = S_DONE;
`ifdef FETCH_LINE_TIMEOUT_EN
          idle_d = '0;
        end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
`endif
        end
      end
      S_DONE: begin
        ready = !err_q;
        if (enable) begin
          state_d = S_ARB;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data  = data_q;
  assign error = err_q;

endmodule

// File: tb/tb_fetch_line.sv
// tb_fetch_line: directed checks of the line fetch engine.
// Inputs change 1 time unit after a rising edge; outputs sampled shortly after.
module tb_fetch_line;

  localparam logic [12:0] TAG = 13'h1100;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [63:0]  addr;
  logic [511:0] data;
  logic         ready;
  logic         error;
  logic [511:0] exp_line;
  int           checks = 0;
  int           errors = 0;

  fetch_line_if #(.DW(64), .TW(13)) bus ();

  fetch_line #(
    .BUS_DATA_WIDTH(64),
    .BUS_TAG_WIDTH (13),
    .LINE_BEATS    (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .addr  (addr),
    .bus   (bus),
    .data  (data),
    .ready (ready),
    .error (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [511:0] o,
                     input logic [511:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", t, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string t);
    chk({t, "_abtr"}, 512'(bus.abtr_reqcyc), 512'(0));
    chk({t, "_busy"}, 512'(bus.bus_busy), 512'(0));
    chk({t, "_reqcyc"}, 512'(bus.main_bus_reqcyc), 512'(0));
    chk({t, "_req"}, 512'(bus.main_bus_req), 512'(0));
    chk({t, "_reqtag"}, 512'(bus.main_bus_reqtag), 512'(0));
    chk({t, "_respack"}, 512'(bus.main_bus_respack), 512'(0));
    chk({t, "_ready"}, 512'(ready), 512'(0));
    chk({t, "_error"}, 512'(error), 512'(0));
  endtask

  task automatic start(input logic [63:0] a);
    enable = 1'b1;
    addr = a;
    bus.abtr_grant = 1'b1;
    bus.main_bus_reqack = 1'b1;
    tick;
    enable = 1'b0;
    chk("arb_req", 512'(bus.abtr_reqcyc), 512'(1));
    tick;
    chk("addr_req", 512'(bus.main_bus_req), 512'({a[63:6], 6'b0}));
    chk("addr_tag", 512'(bus.main_bus_reqtag), 512'(TAG));
    tick;
    bus.abtr_grant = 1'b0;
    bus.main_bus_reqack = 1'b0;
    chk("recv_busy", 512'(bus.bus_busy), 512'(1));
  endtask

  task automatic beat(input int i, input logic [63:0] v);
    bus.main_bus_respcyc = 1'b1;
    bus.main_bus_resp = v;
    bus.main_bus_resptag = TAG;
    #1;
    chk("beat_respack", 512'(bus.main_bus_respack), 512'(1));
    chk("beat_ready_lo", 512'(ready), 512'(0));
    exp_line[i*64 +: 64] = v;
    tick;
    bus.main_bus_respcyc = 1'b0;
    bus.main_bus_resp = '0;
    bus.main_bus_resptag = '0;
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    addr = '0;
    exp_line = '0;
    bus.abtr_grant = 1'b0;
    bus.main_bus_reqack = 1'b0;
    bus.main_bus_respcyc = 1'b0;
    bus.main_bus_resp = '0;
    bus.main_bus_resptag = '0;
    #12;
    chk_quiet("rst");
    chk("rst_data", data, 512'(0));
    reset = 1'b1;
    tick;

    // basic fill, ready on 11th edge after enable
    start(64'h1234_5678_9ABC_DEF7);
    for (int i = 0; i < 8; i++) beat(i, 64'(8'h11 * (i + 1)));
    chk("basic_ready", 512'(ready), 512'(1));
    chk("basic_busy", 512'(bus.bus_busy), 512'(0));
    chk("basic_lo", 512'(data[63:0]), 512'(64'h11));
    chk("basic_hi", 512'(data[511:448]), 512'(64'h88));
    chk("basic_line", data, exp_line);

    // stalls, foreign tag, addr change after capture
    enable = 1'b1;
    addr = 64'h0000_0000_0000_107F;
    tick;
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stall_abtr", 512'(bus.abtr_reqcyc), 512'(1));
      chk("stall_ready", 512'(ready), 512'(0));
      tick;
    end
    bus.abtr_grant = 1'b1;
    #1;
    chk("stall_abtr5", 512'(bus.abtr_reqcyc), 512'(1));
    tick;
    bus.abtr_grant = 1'b0;
    addr = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.main_bus_respcyc = 1'b1;
    bus.main_bus_resp = 64'h77;
    bus.main_bus_resptag = TAG;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("stall_reqcyc", 512'(bus.main_bus_reqcyc), 512'(1));
      chk("stall_addr", 512'(bus.main_bus_req), 512'(64'h1040));
      chk("addr_resp_ign", 512'(bus.main_bus_respack), 512'(0));
      tick;
    end
    bus.main_bus_respcyc = 1'b0;
    bus.main_bus_reqack = 1'b1;
    #1;
    chk("stall_reqcyc3", 512'(bus.main_bus_reqcyc), 512'(1));
    tick;
    bus.main_bus_reqack = 1'b0;
    chk("recv_reqcyc", 512'(bus.main_bus_reqcyc), 512'(0));
    chk("recv_req", 512'(bus.main_bus_req), 512'(0));
    chk("recv_tag", 512'(bus.main_bus_reqtag), 512'(0));
    for (int i = 0; i < 8; i++) begin
      beat(i, 64'hA0 + 64'(i));
      if (i == 3) begin
        bus.main_bus_respcyc = 1'b1;
        bus.main_bus_resp = 64'hDEAD;
        bus.main_bus_resptag = 13'h1000;
        #1;
        chk("foreign_respack", 512'(bus.main_bus_respack), 512'(0));
        tick;
        bus.main_bus_respcyc = 1'b0;
      end
      if (i < 7) begin
        for (int g = 0; g < 2; g++) begin
          #1;
          chk("gap_respack", 512'(bus.main_bus_respack), 512'(0));
          tick;
        end
      end
    end
    chk("stall_ready", 512'(ready), 512'(1));
    chk("stall_line", data, exp_line);

    // back-to-back with enable held high
    enable = 1'b1;
    addr = 64'hFFFF_FFFF_FFFF_FFC5;
    bus.abtr_grant = 1'b1;
    bus.main_bus_reqack = 1'b1;
    tick;
    chk("b2b_ready_lo", 512'(ready), 512'(0));
    chk("b2b_abtr", 512'(bus.abtr_reqcyc), 512'(1));
    tick;
    chk("b2b_addr", 512'(bus.main_bus_req), 512'(64'hFFFF_FFFF_FFFF_FFC0));
    tick;
    bus.abtr_grant = 1'b0;
    bus.main_bus_reqack = 1'b0;
    for (int i = 0; i < 8; i++) beat(i, 64'h100 + 64'(i));
    enable = 1'b0;
    chk("b2b_ready", 512'(ready), 512'(1));
    chk("b2b_line", data, exp_line);

    // asynchronous reset mid-RECV
    start(64'h0000_0000_0000_2000);
    for (int i = 0; i < 4; i++) beat(i, 64'h5500 + 64'(i));
    #2;
    reset = 1'b0;
    #1;
    chk_quiet("midrst");
    chk("midrst_data", data, 512'(0));
    #2;
    reset = 1'b1;
    tick;
    start(64'h0000_0000_0000_3000);
    for (int i = 0; i < 8; i++) beat(i, 64'h6600 + 64'(i));
    chk("refill_ready", 512'(ready), 512'(1));
    chk("refill_line", data, exp_line);

    // stop after 3 beats
    start(64'h0000_0000_0000_4000);
    for (int i = 0; i < 3; i++) beat(i, 64'h7700 + 64'(i));
    for (int k = 0; k < 15; k++) tick;
    chk("idle15_busy", 512'(bus.bus_busy), 512'(1));
    chk("idle15_err", 512'(error), 512'(0));
    tick;
`ifdef FETCH_LINE_TIMEOUT_EN
    chk("to_error", 512'(error), 512'(1));
    chk("to_busy", 512'(bus.bus_busy), 512'(0));
    chk("to_ready", 512'(ready), 512'(0));
`else
    for (int k = 0; k < 20; k++) tick;
    chk("noto_busy", 512'(bus.bus_busy), 512'(1));
    chk("noto_error", 512'(error), 512'(0));
    chk("noto_ready", 512'(ready), 512'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
